reg_spill_ctrl: RTL and testbench

Sequencer that sits on the opposite side of the register-file ports from the datapath. It either spills every register to data memory (`mode`=0) or fills every register back from memory (`mode`=1). It drives the file's `oeb/src` read port and `we/dst/dst_result` write port, and runs a request/acknowledge handshake toward the memory bus. It is used for context save/restore: the core stalls while `busy` is high.

---
 rtl/reg_spill_ctrl.sv | 135 +++++++++++++
 tb/tb_reg_spill_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_spill_ctrl.sv
// Register-file spill/fill sequencer for context save and restore.
// Walks every register through a req/ack memory handshake.
module reg_spill_ctrl #(
  parameter int SIZE = 8,
  parameter int COUNT = 4,
  parameter int ADDR_W = 16,
  localparam int IW = $clog2(COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              rf_oeb,
  output logic [IW-1:0]     rf_src,
  input  logic [SIZE-1:0]   rf_src_dat,
  output logic              rf_we,
  output logic              rf_inc,
  output logic              rf_dec,
  output logic [IW-1:0]     rf_dst,
  output logic [SIZE-1:0]   rf_dst_result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [SIZE-1:0]   mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRD  = 3'd1;
  localparam logic [2:0] S_SWR  = 3'd2;
  localparam logic [2:0] S_FRD  = 3'd3;
  localparam logic [2:0] S_FWR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [ADDR_W-1:0] addr;
  logic              st_srd, st_swr, st_frd, st_fwr;

  assign addr = base_q + ADDR_W'(idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base;
          idx_d   = '0;
          state_d = mode ? S_FRD : S_SRD;
        end
      end
      S_SRD: begin
        data_d  = rf_src_dat;
        state_d = S_SWR;
      end
      S_SWR: begin
        if (mem_ack) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = mode_q ? S_FRD : S_SRD;
          end
        end
      end
      S_FRD: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_FWR;
        end
      end
      S_FWR: begin
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = mode_q ? S_FRD : S_SRD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode from registered state only; mem_ack never reaches them.
  assign st_srd = (state_q == S_SRD);
  assign st_swr = (state_q == S_SWR);
  assign st_frd = (state_q == S_FRD);
  assign st_fwr = (state_q == S_FWR);

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rf_oeb        = st_srd;
  assign rf_src        = st_srd ? idx_q : '0;
  assign rf_we         = st_fwr;
  assign rf_dst        = st_fwr ? idx_q : '0;
  assign rf_dst_result = st_fwr ? data_q : '0;
  assign rf_inc        = 1'b0;
  assign rf_dec        = 1'b0;
  assign mem_wr        = st_swr;
  assign mem_rd        = st_frd;
  assign mem_addr      = (st_swr | st_frd) ? addr : '0;
  assign mem_wdata     = st_swr ? data_q : '0;

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// Bench for reg_spill_ctrl: register-file and memory models,
// table vectors, corner sequences and randomized transfers.
module tb_reg_spill_ctrl;
  localparam int SIZE = 8;
  localparam int COUNT = 4;
  localparam int ADDR_W = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [ADDR_W-1:0] base;
  logic busy, done, rf_oeb, rf_we, rf_inc, rf_dec;
  logic [IW-1:0] rf_src, rf_dst;
  logic [SIZE-1:0] rf_src_dat, rf_dst_result, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_wr, mem_rd, mem_ack;

  reg_spill_ctrl #(.SIZE(SIZE), .COUNT(COUNT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base),
    .busy(busy), .done(done), .rf_oeb(rf_oeb), .rf_src(rf_src),
    .rf_src_dat(rf_src_dat), .rf_we(rf_we), .rf_inc(rf_inc),
    .rf_dec(rf_dec), .rf_dst(rf_dst), .rf_dst_result(rf_dst_result),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [7:0] pat_rf(logic [7:0] s, int i);
    return s + 8'(8'h11 * (i + 1));
  endfunction

  function automatic logic [7:0] pat_mem(logic [7:0] s, int i);
    return s + 8'(i);
  endfunction

  // Environment: register file, memory, ack generator, logs.
  logic [7:0] rf_m [COUNT];
  logic [7:0] mem_m [65536];
  logic [23:0] wlog [$];
  bit ack_always = 0;
  bit ack_rand = 0;
  bit rnd = 0;
  int waits = 0;
  int pend = 0;
  bit pre_go = 0;
  logic [15:0] pre_base = '0;
  logic [7:0] pre_seed = '0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int wait_cnt = 0;

  assign rf_src_dat = rf_m[rf_src];
  assign mem_rdata = mem_m[mem_addr];

  always_comb begin
    mem_ack = ack_always;
    if (ack_rand) mem_ack = mem_ack | rnd;
    else mem_ack = mem_ack | ((mem_wr | mem_rd) && pend >= waits);
  end

  always @(posedge clk) begin
    rnd <= 1'($urandom_range(0, 1));
    pend <= ((mem_wr | mem_rd) && !mem_ack) ? pend + 1 : 0;
    if (pre_go) begin
      for (int i = 0; i < COUNT; i++) begin
        rf_m[i] <= pat_rf(pre_seed, i);
        mem_m[pre_base + 16'(i)] <= pat_mem(pre_seed, i);
      end
    end else begin
      if (rf_we) rf_m[rf_dst] <= rf_dst_result;
      if (mem_wr && mem_ack) mem_m[mem_addr] <= mem_wdata;
    end
    if (mem_wr && mem_ack) wlog.push_back({mem_addr, mem_wdata});
    if (rf_we) we_cnt <= we_cnt + 1;
    if (mem_rd && mem_ack) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if ((mem_wr | mem_rd) && !mem_ack) wait_cnt <= wait_cnt + 1;
  end

  // Per-cycle protocol monitor.
  bit mon_en = 0;
  logic rst_seen = 1'b0;
  logic hold_prev = 1'b0;
  logic prev_rd, prev_wr;
  logic [15:0] prev_addr;
  logic [7:0] prev_wdata;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      logic ok;
      ok = !(mem_wr && mem_rd) && $onehot0({rf_oeb, rf_we, mem_wr, mem_rd});
      ok = ok && !rf_inc && !rf_dec && (!done || busy);
      if (!busy)
        ok = ok && !done && !rf_oeb && !rf_we && !mem_wr && !mem_rd
             && mem_wdata == 0 && rf_dst_result == 0;
      if (!rf_oeb) ok = ok && rf_src == 0;
      if (!rf_we) ok = ok && rf_dst == 0;
      if (!(mem_wr | mem_rd)) ok = ok && mem_addr == 0;
      if (hold_prev && !rst_seen)
        ok = ok && mem_rd == prev_rd && mem_wr == prev_wr
             && mem_addr == prev_addr && mem_wdata == prev_wdata;
      check("protocol", 32'(ok), 32'd1);
    end
    hold_prev <= (mem_wr | mem_rd) && !mem_ack;
    prev_rd <= mem_rd;
    prev_wr <= mem_wr;
    prev_addr <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  task automatic preload(input logic [15:0] b, input logic [7:0] s);
    @(negedge clk);
    pre_go = 1;
    pre_base = b;
    pre_seed = s;
    @(negedge clk);
    pre_go = 0;
  endtask

  task automatic wait_done(output int lat, output bit got);
    lat = 0;
    got = 0;
    while (lat < 400 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 0;
      if (done) got = 1;
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic check_spill(input int w0, input logic [15:0] b,
                             input logic [7:0] s);
    for (int i = 0; i < COUNT; i++)
      if (w0 + i < wlog.size())
        check("spill_entry", 32'(wlog[w0 + i]),
              32'({16'(b + 16'(i)), pat_rf(s, i)}));
  endtask

  task automatic run_vec(input bit md, input logic [15:0] b, input int w,
                         input bit rack, input bit aack,
                         input logic [7:0] s, input int exp_lat);
    int w0, we0, rd0, d0, wc0, lat;
    bit got;
    waits = w;
    ack_rand = rack;
    ack_always = aack;
    preload(b, s);
    w0 = wlog.size();
    we0 = we_cnt;
    rd0 = rd_cnt;
    d0 = done_cnt;
    wc0 = wait_cnt;
    start = 1;
    mode = md;
    base = b;
    wait_done(lat, got);
    if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
    check("lat_vs_waits", 32'(lat), 32'(1 + 2 * COUNT + wait_cnt - wc0));
    @(posedge clk);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    if (!md) begin
      check("spill_writes", 32'(wlog.size() - w0), 32'(COUNT));
      check_spill(w0, b, s);
      check("spill_no_rf_we", 32'(we_cnt - we0), 32'd0);
      for (int i = 0; i < COUNT; i++)
        check("spill_rf_kept", 32'(rf_m[i]), 32'(pat_rf(s, i)));
    end else begin
      check("fill_no_mem_wr", 32'(wlog.size() - w0), 32'd0);
      check("fill_we_count", 32'(we_cnt - we0), 32'(COUNT));
      check("fill_rd_count", 32'(rd_cnt - rd0), 32'(COUNT));
      for (int i = 0; i < COUNT; i++)
        check("fill_rf", 32'(rf_m[i]), 32'(pat_mem(s, i)));
    end
  endtask

  typedef struct {
    bit md;
    logic [15:0] b;
    int w;
    bit aack;
    logic [7:0] seed;
    int lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat, n, d0, w0;
    bit got, found;

    tbl[0] = '{1'b0, 16'h0010, 0, 1'b1, 8'h00, 9};
    tbl[1] = '{1'b1, 16'h0020, 2, 1'b0, 8'hA0, 17};
    tbl[2] = '{1'b0, 16'hFFFE, 0, 1'b0, 8'h05, 9};
    tbl[3] = '{1'b1, 16'hFFFD, 1, 1'b0, 8'h3C, 13};
    tbl[4] = '{1'b0, 16'h1234, 3, 1'b0, 8'h77, 21};
    tbl[5] = '{1'b1, 16'h0100, 0, 1'b1, 8'h10, 9};

    rst = 1;
    start = 0;
    mode = 0;
    base = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl",
          {24'd0, busy, done, rf_oeb, rf_we, mem_wr, mem_rd, rf_inc, rf_dec},
          32'd0);
    check("reset_idx", {28'd0, rf_src, rf_dst}, 32'd0);
    check("reset_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
    check("reset_result", 32'(rf_dst_result), 32'd0);
    rst = 0;
    mon_en = 1;

    ack_always = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_spurious_ack", {31'd0, busy}, 32'd0);
    end

    foreach (tbl[k])
      run_vec(tbl[k].md, tbl[k].b, tbl[k].w, 1'b0, tbl[k].aack,
              tbl[k].seed, tbl[k].lat);

    // Reset during the FILL_RD of register 2.
    ack_always = 0;
    ack_rand = 0;
    waits = 2;
    preload(16'h0040, 8'h50);
    d0 = done_cnt;
    start = 1;
    mode = 1;
    base = 16'h0040;
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 0;
      if (mem_rd && mem_addr == 16'h0042) found = 1;
    end
    check("reach_fill_rd2", 32'(found), 32'd1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("abort_ctl", {26'd0, busy, done, rf_oeb, rf_we, mem_wr, mem_rd},
          32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_rf0", 32'(rf_m[0]), 32'(pat_mem(8'h50, 0)));
    check("abort_rf1", 32'(rf_m[1]), 32'(pat_mem(8'h50, 1)));
    check("abort_rf2", 32'(rf_m[2]), 32'(pat_rf(8'h50, 2)));
    check("abort_rf3", 32'(rf_m[3]), 32'(pat_rf(8'h50, 3)));

    // Extra starts while busy, then one held through DONE into IDLE.
    waits = 1;
    preload(16'h0300, 8'h20);
    d0 = done_cnt;
    w0 = wlog.size();
    start = 1;
    mode = 0;
    base = 16'h0300;
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == 3 || n == 4);
      mode = 1;
      base = 16'h0999;
      if (done) got = 1;
    end
    check("busy_done_seen", 32'(got), 32'd1);
    start = 1;
    mode = 0;
    base = 16'h0400;
    @(posedge clk);
    @(negedge clk);
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_writes", 32'(wlog.size() - w0), 32'(COUNT));
    check_spill(w0, 16'h0300, 8'h20);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("start_after_done", {31'd0, busy}, 32'd1);
    wait_done(lat, got);
    @(posedge clk);
    @(negedge clk);
    check("second_done_count", 32'(done_cnt - d0), 32'd2);
    check("second_writes", 32'(wlog.size() - w0), 32'(2 * COUNT));
    check_spill(w0 + COUNT, 16'h0400, 8'h20);

    for (int r = 0; r < 30; r++)
      run_vec(1'($urandom_range(0, 1)), 16'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
              8'($urandom), -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
